// File: rtl/data_mem_pipe_if.sv
// data_mem_pipe_if: request/response bus of the data memory.
//   Write side : wEn, wAddr, wData, wMask (byte enables, bit i -> wData[8i+7:8i])
//   Read side  : rEn, rAddr -> mem_out, rValid
//   Status     : ready (memory accepts requests)
//   Parity     : injErr (in), parErr (out), present only with DATA_MEM_PARITY_EN
// master = load/store unit side, slave = memory side.
interface data_mem_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) ();
    logic                      wEn;
    logic [ADDR_WIDTH-1:0]     wAddr;
    logic [DATA_WIDTH-1:0]     wData;
    logic [DATA_WIDTH/8-1:0]   wMask;
    logic                      rEn;
    logic [ADDR_WIDTH-1:0]     rAddr;
    logic [DATA_WIDTH-1:0]     mem_out;
    logic                      rValid;
    logic                      ready;
`ifdef DATA_MEM_PARITY_EN
    logic                      injErr;
    logic                      parErr;
`endif

    modport master (
        output wEn, wAddr, wData, wMask, rEn, rAddr,
`ifdef DATA_MEM_PARITY_EN
        output injErr,
        input  parErr,
`endif
        input  mem_out, rValid, ready
    );

    modport slave (
        input  wEn, wAddr, wData, wMask, rEn, rAddr,
`ifdef DATA_MEM_PARITY_EN
        input  injErr,
        output parErr,
`endif
        output mem_out, rValid, ready
    );
endinterface

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: simple dual-port (1W/1R) synchronous RAM with byte masks,
// READ_LATENCY-deep registered read pipeline (1..3), read-valid strobe and
// write-first bypass on same-address collisions. After reset a sequencer
// zero-fills the whole array before ready rises.
//
// Ports:
//   clk   - single clock, rising edge
//   rstN  - asynchronous active-low reset
//   bus   - data_mem_pipe_if.slave (write/read requests, mem_out, rValid, ready)
//
// Optional build macro DATA_MEM_PARITY_EN adds one even-parity bit per byte,
// the injErr input and the parErr strobe (aligned with rValid).
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | zero-fill one word per edge, requests ignored, ready = 0
// RUN   | normal operation, ready = 1, left only by reset
module data_mem_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rstN,
    data_mem_pipe_if.slave     bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LAT   = READ_LATENCY;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NB-1:0]           mem_wmask;
    logic                    rd_accept;
    logic                    collide;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [LAT-1:0]          vld_q, vld_d;
    logic [DATA_WIDTH-1:0]   dat_q [LAT];
    logic [DATA_WIDTH-1:0]   dat_d [LAT];

    // ---------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = bus.wAddr;
        mem_wdata  = bus.wData;
        mem_wmask  = bus.wMask;
        rd_accept  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                mem_we     = 1'b1;
                mem_waddr  = clr_addr_q;
                mem_wdata  = '0;
                mem_wmask  = '1;
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if (&clr_addr_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                mem_we    = bus.wEn;
                rd_accept = bus.rEn;
            end
        endcase
    end

    assign bus.ready = (state_q == RUN);

    // ---------------------------------------------------------------
    // Storage (contents are not reset; CLEAR initialises them)
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wmask[i]) begin
                    mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Write-first: a same-edge write to the read address overrides the
    // stored bytes it enables, so the read sees the merged word.
    always_comb begin
        collide = (state_q == RUN) && bus.wEn && bus.rEn && (bus.wAddr == bus.rAddr);
        rd_word = mem_q[bus.rAddr];
        for (int i = 0; i < NB; i++) begin
            if (collide && bus.wMask[i]) begin
                rd_word[8*i +: 8] = bus.wData[8*i +: 8];
            end
        end
    end

    // ---------------------------------------------------------------
    // Read pipeline. Stage 0 is loaded on the accepting edge; the last
    // stage drives the outputs. Data stages only load behind a valid
    // entry, which makes mem_out hold the last result between reads.
    // ---------------------------------------------------------------
    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = rd_accept;
        if (rd_accept) begin
            dat_d[0] = rd_word;
        end
        for (int k = 1; k < LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
                dat_d[k] = dat_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            vld_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < LAT; k++) begin
                dat_q[k] <= dat_d[k];
            end
        end
    end

    assign bus.rValid  = vld_q[LAT-1];
    assign bus.mem_out = dat_q[LAT-1];

`ifdef DATA_MEM_PARITY_EN
    // ---------------------------------------------------------------
    // Parity: one even-parity bit per byte. CLEAR writes zero data, so
    // its computed parity is 0 as well.
    // ---------------------------------------------------------------
    logic [NB-1:0]  par_q [DEPTH];
    logic [NB-1:0]  wr_par;
    logic [NB-1:0]  rd_par;
    logic           rd_err;
    logic [LAT-1:0] perr_q, perr_d;

    always_comb begin
        wr_par = '0;
        rd_par = par_q[bus.rAddr];
        rd_err = 1'b0;
        for (int i = 0; i < NB; i++) begin
            wr_par[i] = (^mem_wdata[8*i +: 8]) ^ ((state_q == RUN) && bus.injErr);
            if (collide && bus.wMask[i]) begin
                rd_par[i] = wr_par[i];
            end
            if ((^rd_word[8*i +: 8]) != rd_par[i]) begin
                rd_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wmask[i]) begin
                    par_q[mem_waddr][i] <= wr_par[i];
                end
            end
        end
    end

    always_comb begin
        perr_d    = '0;
        perr_d[0] = rd_accept && rd_err;
        for (int k = 1; k < LAT; k++) begin
            perr_d[k] = perr_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            perr_q <= '0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.parErr = perr_q[LAT-1];
`endif

endmodule

// File: tb/tb_data_mem_pipe.sv
module tb_data_mem_pipe;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 16;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    data_mem_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_mem_pipe #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(LAT)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    int          nchk = 0;
    int          nfail = 0;
    int          edges = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [3:0]  ref_bad [DEPTH];
    logic [31:0] last_out = '0;
    logic        inj_drv = 1'b0;
    exp_t        expq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nchk++;
        assert (obs === exp_v)
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] wm, input bit re, input logic [3:0] ra);
        bus.wEn   = we;
        bus.wAddr = wa;
        bus.wData = wd;
        bus.wMask = wm;
        bus.rEn   = re;
        bus.rAddr = ra;
`ifdef DATA_MEM_PARITY_EN
        bus.injErr = inj_drv;
`endif
    endtask

    // One clock: drive, model the edge, check outputs #1 after it.
    task automatic cyc(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] wm, input bit re, input logic [3:0] ra);
        bit   acc;
        exp_t e;
        drive(we, wa, wd, wm, re, ra);
        @(posedge clk);
        acc = (edges >= DEPTH);
        edges++;
        if (edges == DEPTH) begin
            for (int a = 0; a < DEPTH; a++) begin
                ref_mem[a] = '0;
                ref_bad[a] = '0;
            end
        end
        if (acc && we) begin
            for (int b = 0; b < 4; b++) begin
                if (wm[b]) begin
                    ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
                    ref_bad[wa][b]        = inj_drv;
                end
            end
        end
        if (acc && re) begin
            e.cyc  = edges + LAT - 1;
            e.data = ref_mem[ra];
            e.err  = |ref_bad[ra];
            expq.push_back(e);
        end
        #1;
        chk("ready", {31'd0, bus.ready}, {31'd0, edges >= DEPTH});
        if (expq.size() > 0 && expq[0].cyc == edges) begin
            e = expq.pop_front();
            chk("rvalid_hi", {31'd0, bus.rValid}, 32'd1);
            chk("rdata", bus.mem_out, e.data);
            last_out = e.data;
`ifdef DATA_MEM_PARITY_EN
            chk("parerr", {31'd0, bus.parErr}, {31'd0, e.err});
`endif
        end else begin
            chk("rvalid_lo", {31'd0, bus.rValid}, 32'd0);
            chk("hold", bus.mem_out, last_out);
`ifdef DATA_MEM_PARITY_EN
            chk("parerr_lo", {31'd0, bus.parErr}, 32'd0);
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'd0, 32'd0, 4'd0, 0, 4'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        cyc(1, a, d, m, 0, 4'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(0, 4'd0, 32'd0, 4'd0, 1, a);
    endtask

    // Asserts reset asynchronously (mid-cycle), holds it two edges, releases on a negedge.
    task automatic do_reset();
        drive(0, 4'd0, 32'd0, 4'd0, 0, 4'd0);
        rstN = 1'b0;
        #1;
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_rvalid", {31'd0, bus.rValid}, 32'd0);
        chk("rst_mem_out", bus.mem_out, 32'd0);
        expq.delete();
        last_out = '0;
        edges    = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_rvalid_hold", {31'd0, bus.rValid}, 32'd0);
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  wa, ra, wm;
        logic [31:0] wd;
        bit          we, re;

        // Reset, then requests during CLEAR must be ignored.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 4'(i / 2), $urandom, 4'hF, 1, 4'($urandom));
        end
        for (int a = 0; a < DEPTH; a++) rd(4'(a));
        idle(LAT);
        chk("zero_fill_last", bus.mem_out, 32'h0000_0000);

        // Latency: DEADBEEF at address 3.
        wr(4'd3, 32'hDEAD_BEEF, 4'hF);
        idle(1);
        rd(4'd3);
        idle(LAT + 1);
        chk("latency_data", bus.mem_out, 32'hDEAD_BEEF);

        // Byte mask merge.
        wr(4'd5, 32'h1122_3344, 4'hF);
        wr(4'd5, 32'hAABB_CCDD, 4'b0101);
        rd(4'd5);
        idle(LAT);
        chk("mask_merge", bus.mem_out, 32'h11BB_33DD);

        // Zero mask is a no-op.
        wr(4'd5, 32'hFFFF_FFFF, 4'b0000);
        rd(4'd5);
        idle(LAT);
        chk("mask_zero", bus.mem_out, 32'h11BB_33DD);

        // Same-edge write/read collision, full and partial mask.
        wr(4'd7, 32'h1234_5678, 4'hF);
        cyc(1, 4'd7, 32'h0000_FFFF, 4'hF, 1, 4'd7);
        idle(LAT);
        chk("collide_full", bus.mem_out, 32'h0000_FFFF);
        cyc(1, 4'd7, 32'hA5A5_A5A5, 4'b1000, 1, 4'd7);
        idle(LAT);
        chk("collide_part", bus.mem_out, 32'hA500_FFFF);

        // Back-to-back reads.
        wr(4'd0, 32'd32, 4'hF);
        wr(4'd1, 32'd33, 4'hF);
        wr(4'd2, 32'd34, 4'hF);
        rd(4'd0);
        rd(4'd1);
        rd(4'd2);
        idle(LAT + 1);

        // Random traffic, biased toward collisions.
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = 4'($urandom);
            wd = $urandom;
            wm = 4'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
            cyc(we, wa, wd, wm, re, ra);
        end
        idle(LAT);

        // Reset while a read is in flight.
        wr(4'd9, 32'hCAFE_F00D, 4'hF);
        rd(4'd9);
        do_reset();
        idle(DEPTH);

        // Reset mid-CLEAR: ready must take a full DEPTH edges again.
        do_reset();
        idle(7);
        do_reset();
        idle(DEPTH);
        rd(4'd9);
        rd(4'd3);
        idle(LAT);
        chk("cleared_after_reset", bus.mem_out, 32'h0000_0000);

`ifdef DATA_MEM_PARITY_EN
        inj_drv = 1'b1;
        wr(4'd4, 32'h0F0F_0001, 4'b0001);
        inj_drv = 1'b0;
        rd(4'd4);
        idle(LAT);
        wr(4'd4, 32'h0000_0003, 4'hF);
        rd(4'd4);
        idle(LAT);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/data_mem_pipe.md
# data_mem_pipe

Parametrised successor to the team's single-port data memory: a simple dual-port (one write, one read) synchronous RAM with byte-lane write masks, configurable read-pipeline latency, a read-valid strobe and write-first collision bypass. After reset, an internal sequencer zero-fills the array before the memory accepts traffic. It sits between the datapath load/store unit and the address decoder. The load/store unit gates requests on `ready` and consumes results on `rValid`.

## Interface
- `DATA_WIDTH`, default 32: word width in bits. Must be a multiple of 8.
- `ADDR_WIDTH`, default 8: address width in bits. Depth is DEPTH = 2**ADDR_WIDTH words.
- `READ_LATENCY`, default 1: number of clock edges from read request to data. Legal values are 1 to 3.

- `clk` input, 1 bit: the single clock. All state updates on its rising edge.
- `rstN` input, 1 bit: asynchronous, active-low reset.
- `wEn` input, 1 bit: write request.
- `wAddr` input, ADDR_WIDTH bits: write address.
- `wData` input, DATA_WIDTH bits: write data.
- `wMask` input, DATA_WIDTH/8 bits: byte enables. Bit i enables byte i, which is wData[8i+7:8i].
- `rEn` input, 1 bit: read request.
- `rAddr` input, ADDR_WIDTH bits: read address.
- `mem_out` output, DATA_WIDTH bits: read data.
- `rValid` output, 1 bit: one-cycle strobe marking `mem_out` as valid for one read.
- `ready` output, 1 bit: high when the memory accepts requests.
- `parErr` output, 1 bit: parity error strobe. Present only with DATA_MEM_PARITY_EN.
- `injErr` input, 1 bit: parity error injection. Present only with DATA_MEM_PARITY_EN.

## Operation
- FSM states: CLEAR and RUN.
- While `rstN` is low:
  - state = CLEAR, clear counter = 0.
  - `ready`, `rValid`, `mem_out` (all bits), `parErr` and all pipeline valid bits are 0.
- CLEAR state:
  - Each rising edge writes 0 to all bytes of mem[clrAddr], then increments clrAddr.
  - The edge that writes address DEPTH-1 moves the FSM to RUN.
  - `wEn` and `rEn` are ignored in CLEAR.
- RUN state:
  - `ready` = 1.
  - RUN is left only by reset.
- Write: at an edge with `ready` && `wEn`, mem[wAddr] byte i takes wData byte i where wMask[i] = 1. Other bytes keep their contents.
  - wMask = 0 is a legal no-op.
- Read: at an edge with `ready` && `rEn`, the request enters the read pipeline.
  - One read per cycle is accepted, with no bubbles.
- Collision (write-first): `wEn` and `rEn` on the same edge with wAddr == rAddr. The read returns the merged word: masked bytes from wData, unmasked bytes from the old contents.
- Different-address writes and reads on the same edge are independent.
- `mem_out` holds the last read result while `rValid` is low.
- Addresses wrap naturally at ADDR_WIDTH bits. There is no out-of-range condition.
- Reset asserted mid-CLEAR or mid-read:
  - In-flight reads are discarded, with no `rValid`.
  - CLEAR restarts from address 0.
  - Array contents are not guaranteed until CLEAR completes.

## Timing
- `ready` rises after edge DEPTH counted from the first edge with `rstN` high. That edge is the one writing address DEPTH-1.
- Read accepted at edge N:
  - `rValid` = 1 and `mem_out` = data, both registered after edge N+READ_LATENCY-1.
  - `rValid` falls after the next edge unless another read is accepted.
- Write accepted at edge N is visible to a read accepted at edge N, via the bypass, and to any later read.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `DATA_MEM_PARITY_EN`.
- Defined:
  - Each byte stores an extra even-parity bit, computed on write. CLEAR stores parity 0.
  - While `injErr` = 1 on a write, the stored parity of every written byte is inverted.
  - Reads check parity. `parErr` = 1 aligned with `rValid` if any byte mismatches, and is otherwise 0.
  - The bypass path forwards the freshly computed, possibly inverted, parity.
- Undefined: no parity storage, and the `parErr` and `injErr` ports are absent. Data behaviour is identical in both builds.

## Test plan
All scenarios use DATA_WIDTH=32 and ADDR_WIDTH=4 (DEPTH=16).
- Reset, release, idle. Required: `ready` = 0 for 16 edges, then 1. A read of every address returns 0x00000000 with one `rValid` pulse each.
- READ_LATENCY=2: write 0xDEADBEEF to address 3, then issue `rEn` at address 3 at edge N. Required: `rValid` and `mem_out` = 0xDEADBEEF after edge N+1 only.
- Address 5 holds 0x11223344. Write wData 0xAABBCCDD with wMask 4'b0101. Required: a readback returns 0x11BB33DD.
- Same-edge write of 0x0000FFFF with full mask and read of address 7, which holds 0x12345678. Required: the read returns 0x0000FFFF.
- Back-to-back reads of addresses 0, 1 and 2, holding 32, 33 and 34. Required: three consecutive `rValid` cycles with `mem_out` 32, 33, 34.
- Assert `rstN` low mid-CLEAR and while a read is in flight. Required: no `rValid`, and `ready` returns only after a full 16 edges. With DATA_MEM_PARITY_EN, a write with `injErr`=1 followed by a read of the same address gives `parErr` = 1 with `rValid`.
